iref_ctrl: RTL and testbench

- Power-sequencing controller for the current reference generator (IREF) analog macro.
- Drives the macro's iref_pd and iref_charge pins in the required order: pd released first, charge held high for a programmable time, then charge released.
- Reports a ready level to the transceiver/ADC blocks that consume the reference current.
- Sits between the SoC power-management registers and the IREF macro.

---
 rtl/iref_ctrl.sv | 139 +++++++++++++
 tb/tb_iref_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/iref_ctrl.sv
// ---------------------------------------------------------------------------
// iref_ctrl -- power-sequencing controller for the IREF analog macro.
//
// Releases iref_pd first, holds iref_charge high for max(charge_cycles,1)
// cycles, then releases iref_charge and reports ready. All outputs are
// flops decoded from the next state, so nothing combinational reaches a pin.
//
// en is registered once before it steers the FSM. "en sampled at edge N"
// means r_en captures it at N. The state reacts at N+1, so every output
// change lands one edge after the en sample.
//
// Optional feature (compile-time macro IREF_CTRL_SETTLE_EN):
//   inserts a SETTLE state of SETTLE_CYCLES cycles between CHARGE and ON.
//   In this state charge is already released, but ready stays low.
//
// Parameters:
//   CNT_W         charge counter / charge_cycles width
//   SETTLE_CYCLES settle length in cycles (only with IREF_CTRL_SETTLE_EN, >=1)
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active-high
//   en             level request: 1 = reference on, 0 = power down
//   charge_cycles  charge length, captured on OFF->CHARGE only
//   iref_pd        macro power-down pin (1 = powered down)
//   iref_charge    macro fast-charge pin (1 = charging / default)
//   ready          reference current valid and stable
//   busy           power-up sequence in progress
// ---------------------------------------------------------------------------
module iref_ctrl #(
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] charge_cycles,
    output logic             iref_pd,
    output logic             iref_charge,
    output logic             ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_CHARGE = 2'd1,
        S_SETTLE = 2'd2,
        S_ON     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic             r_en;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    // The counter is loaded with the number of cycles to spend in the
    // phase, and the phase ends when it reaches 1. The counter therefore
    // never decrements through zero, so an all-ones load cannot wrap.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_OFF: begin
                w_cnt_next = '0;
                if (r_en) begin
                    w_next     = S_CHARGE;
                    w_cnt_next = (charge_cycles == '0) ? ONE : charge_cycles;
                end
            end
            S_CHARGE: begin
                if (!r_en) begin
                    w_next     = S_OFF;
                    w_cnt_next = '0;
                end else if (r_cnt <= ONE) begin
`ifdef IREF_CTRL_SETTLE_EN
                    w_next     = S_SETTLE;
                    w_cnt_next = CNT_W'(SETTLE_CYCLES);
`else
                    w_next     = S_ON;
                    w_cnt_next = '0;
`endif
                end else begin
                    w_cnt_next = r_cnt - ONE;
                end
            end
            S_SETTLE: begin
`ifdef IREF_CTRL_SETTLE_EN
                if (!r_en) begin
                    w_next     = S_OFF;
                    w_cnt_next = '0;
                end else if (r_cnt <= ONE) begin
                    w_next     = S_ON;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt - ONE;
                end
`else
                // Unreachable without the settle phase; recover to OFF.
                w_next     = S_OFF;
                w_cnt_next = '0;
`endif
            end
            S_ON: begin
                w_cnt_next = '0;
                if (!r_en) w_next = S_OFF;
            end
            default: begin
                w_next     = S_OFF;
                w_cnt_next = '0;
            end
        endcase
    end

    // Outputs are decoded from w_next, so each pin flips on the same edge
    // as the state. iref_charge is low only in SETTLE/ON, and those states
    // are reached only through CHARGE, where iref_pd is already low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_OFF;
            r_cnt       <= '0;
            r_en        <= 1'b0;
            iref_pd     <= 1'b1;
            iref_charge <= 1'b1;
            ready       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_en        <= en;
            iref_pd     <= (w_next == S_OFF);
            iref_charge <= (w_next == S_OFF) || (w_next == S_CHARGE);
            ready       <= (w_next == S_ON);
            busy        <= (w_next == S_CHARGE) || (w_next == S_SETTLE);
        end
    end

endmodule

// File: tb/tb_iref_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iref_ctrl -- scoreboard bench for iref_ctrl.
// Stimulus pushes cycle-stamped expected pin values into a queue. The
// monitor compares on the negedge of each stamped cycle and also checks
// the pd/charge invariant on every cycle out of reset. Edge k is the k-th
// posedge, and cyc == k between edge k and edge k+1.
// ---------------------------------------------------------------------------
module tb_iref_ctrl;
    localparam int CNT_W = 16;
    localparam int SC    = 8;
`ifdef IREF_CTRL_SETTLE_EN
    localparam int SX = SC;
`else
    localparam int SX = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b0;
    logic [CNT_W-1:0] cc  = '0;
    logic             iref_pd, iref_charge, ready, busy;

    iref_ctrl #(.CNT_W(CNT_W), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .en(en), .charge_cycles(cc),
        .iref_pd(iref_pd), .iref_charge(iref_charge), .ready(ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    c;
        logic  pd, ch, rdy, bsy;
        string nm;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    task automatic push(input int c, input logic pd, input logic ch,
                        input logic rdy, input logic bsy, input string nm);
        exp_t x;
        x.c = c; x.pd = pd; x.ch = ch; x.rdy = rdy; x.bsy = bsy; x.nm = nm;
        q.push_back(x);
    endtask

    // Expected trace for a full power-up; n is the edge that samples en=1.
    task automatic exp_seq(input int n, input int c, input string nm);
        push(n,     1, 1, 0, 0, {nm, "_off"});
        push(n + 1, 0, 1, 0, 1, {nm, "_chg_first"});
        if (c > 1) push(n + c, 0, 1, 0, 1, {nm, "_chg_last"});
`ifdef IREF_CTRL_SETTLE_EN
        push(n + 1 + c,      0, 0, 0, 1, {nm, "_settle_first"});
        push(n + c + SC,     0, 0, 0, 1, {nm, "_settle_last"});
        push(n + 1 + c + SC, 0, 0, 1, 0, {nm, "_on"});
`else
        push(n + 1 + c, 0, 0, 1, 0, {nm, "_on"});
`endif
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic power_down(input string nm);
        int t;
        t  = cyc;
        en = 1'b0;
        push(t + 1, 0, 0, 1, 0, {nm, "_pdn_hold"});
        push(t + 2, 1, 1, 0, 0, {nm, "_pdn_off"});
        at(t + 4);
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (iref_pd === 1'b1 && iref_charge !== 1'b1) begin
                errors++;
                $display("FAIL invariant cyc=%0d got pd=%b charge=%b, need charge=1 while pd=1",
                         cyc, iref_pd, iref_charge);
            end
        end
        while (q.size() > 0 && q[0].c < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s missed sample for cyc=%0d", e.nm, e.c);
        end
        if (q.size() > 0 && q[0].c == cyc) begin
            e = q.pop_front();
            checks++;
            if ({iref_pd, iref_charge, ready, busy} !== {e.pd, e.ch, e.rdy, e.bsy}) begin
                errors++;
                $display("FAIL %s cyc=%0d got pd/ch/rdy/busy=%b%b%b%b expected %b%b%b%b",
                         e.nm, cyc, iref_pd, iref_charge, ready, busy,
                         e.pd, e.ch, e.rdy, e.bsy);
            end
        end
    end

    initial begin
        int t, n;
        // Reset state.
        repeat (3) @(negedge clk);
        t = cyc;
        push(t + 1, 1, 1, 0, 0, "reset_state");
        @(negedge clk);
        rst = 1'b0;
        push(cyc + 1, 1, 1, 0, 0, "post_reset_idle");
        at(cyc + 3);

        // Nominal power-up, charge_cycles=10, then power-down from ON.
        t = cyc; en = 1'b1; cc = 16'd10; n = t + 1;
        exp_seq(n, 10, "nom");
        at(n + 11 + SX + 2);
        power_down("nom");

        // Zero charge_cycles behaves as one.
        t = cyc; en = 1'b1; cc = 16'd0; n = t + 1;
        exp_seq(n, 1, "zero");
        at(n + 2 + SX + 2);
        power_down("zero");

        // Abort: charge_cycles changed mid-charge is ignored; en dropped at
        // cycle 30; en re-raised the next cycle gives a full new sequence.
        t = cyc; en = 1'b1; cc = 16'd50; n = t + 1;
        push(n + 1, 0, 1, 0, 1, "abort_chg_first");
        push(n + 25, 0, 1, 0, 1, "abort_cc_ignored");
        push(n + 30, 0, 1, 0, 1, "abort_still_chg");
        at(n + 20);
        cc = 16'd5;
        at(n + 30);
        en = 1'b0; cc = 16'd50;
        push(n + 31, 0, 1, 0, 1, "abort_hold");
        @(negedge clk);
        en = 1'b1;
        exp_seq(n + 32, 50, "restart");
        at(n + 32 + 51 + SX + 2);
        power_down("restart");

        // Asynchronous reset mid-charge, then restart with en held high.
        t = cyc; en = 1'b1; cc = 16'd100; n = t + 1;
        push(n + 1, 0, 1, 0, 1, "rst_chg_first");
        push(n + 40, 0, 1, 0, 1, "rst_chg_40");
        at(n + 40);
        @(posedge clk);
        #2 rst = 1'b1;
        push(n + 41, 1, 1, 0, 0, "rst_async");
        push(n + 42, 1, 1, 0, 0, "rst_held");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_seq(cyc + 1, 100, "rst_restart");
        at(cyc + 1 + 101 + SX + 2);
        power_down("rst_restart");

        // Maximum charge_cycles: no early wrap.
        t = cyc; en = 1'b1; cc = 16'hFFFF; n = t + 1;
        exp_seq(n, 65535, "max");
        at(n + 65536 + SX + 2);
        power_down("max");

`ifdef IREF_CTRL_SETTLE_EN
        // en dropped during SETTLE.
        t = cyc; en = 1'b1; cc = 16'd10; n = t + 1;
        push(n + 1, 0, 1, 0, 1, "sabort_chg");
        push(n + 11, 0, 0, 0, 1, "sabort_settle");
        push(n + 13, 0, 0, 0, 1, "sabort_settle_mid");
        at(n + 13);
        en = 1'b0;
        push(n + 14, 0, 0, 0, 1, "sabort_hold");
        push(n + 15, 1, 1, 0, 0, "sabort_off");
        at(n + 17);
`endif

        // Random en toggles; the monitor checks the invariant every cycle.
        for (int i = 0; i < 1000; i++) begin
            en = ~en;
            cc = CNT_W'($urandom_range(0, 20));
            repeat ($urandom_range(1, 12)) @(negedge clk);
        end
        en = 1'b0;
        at(cyc + 4);
        while (q.size() > 0 && cyc < 200000) @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
